// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. It sends one command byte to the attached
// PS/2 device over the shared open-drain clock/data lines. A frame is built as
// follows:
//   1. Hold the clock low (inhibit).
//   2. Request-to-send (data low while the clock is still held low).
//   3. Shift out 8 data bits LSB first, odd parity and the stop bit, each
//      updated after a device clock fall.
//   4. Check the device acknowledge bit.
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   start    in   send request, sampled only while idle
//   tx_data  in   byte to send, latched when start is accepted
//   ps2c_in  in   PS/2 clock pin level (asynchronous)
//   ps2d_in  in   PS/2 data pin level (asynchronous)
//   ps2c_oe  out  1 = pull PS/2 clock low
//   ps2d_oe  out  1 = pull PS/2 data low
//   busy     out  transfer in progress
//   done     out  one-cycle pulse at the end of every transfer
//   ack_err  out  1 = no device ack or timeout; valid with done, held until next start
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    // One counter serves both the inhibit interval and the inter-fall timeout,
    // so it is sized for the larger of the two.
    localparam int MAX_CNT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic             c_s1_q, c_s2_q, c_prev_q;
    logic             d_s1_q, d_s2_q;
    logic             fall;
    logic [8:0]       sh_q, sh_d;
    logic [3:0]       bit_q, bit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_oe_q, c_oe_d;
    logic             d_oe_q, d_oe_d;
    logic             err_q, err_d;

    // Synchronizers reset to the released (pulled-up) bus level so that
    // leaving reset never looks like a clock fall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_s1_q   <= 1'b1;
            c_s2_q   <= 1'b1;
            c_prev_q <= 1'b1;
            d_s1_q   <= 1'b1;
            d_s2_q   <= 1'b1;
        end else begin
            c_s1_q   <= ps2c_in;
            c_s2_q   <= c_s1_q;
            c_prev_q <= c_s2_q;
            d_s1_q   <= ps2d_in;
            d_s2_q   <= d_s1_q;
        end
    end

    assign fall = c_prev_q & ~c_s2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            c_oe_q  <= 1'b0;
            d_oe_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            c_oe_q  <= c_oe_d;
            d_oe_q  <= d_oe_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        d_oe_d  = d_oe_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Shift register holds {odd parity, data}; LSB goes first.
                    sh_d    = {~^tx_data, tx_data};
                    bit_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    d_oe_d  = 1'b0;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d   = '0;
                    d_oe_d  = 1'b1;   // start bit, driven while the clock is still held
                    state_d = S_RTS;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RTS: begin
                cnt_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (fall) begin
                    cnt_d = '0;
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd9) begin
                        // Tenth fall: release data for the stop bit.
                        d_oe_d  = 1'b0;
                        state_d = S_ACK;
                    end else begin
                        d_oe_d = ~sh_q[0];
                        sh_d   = {1'b0, sh_q[8:1]};
                    end
                end else if (cnt_q == TMO_LAST) begin
                    d_oe_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ACK: begin
                if (fall) begin
                    cnt_d   = '0;
                    bit_d   = bit_q + 4'd1;
                    err_d   = d_s2_q;   // device must pull data low to acknowledge
                    state_d = S_WAIT_IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (c_s2_q && d_s2_q) begin
                    state_d = S_DONE;
                end else if (fall) begin
                    cnt_d = '0;
                end else if (cnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Clock drive is registered from the next state so the pin never glitches.
        c_oe_d = (state_d == S_INHIBIT) || (state_d == S_RTS);
    end

    assign ps2c_oe = c_oe_q;
    assign ps2d_oe = d_oe_q;
    assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done    = (state_q == S_DONE);
    assign ack_err = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int INH  = 8;
    localparam int TMO  = 200;
    localparam int HALF = 20;   // device clock half period: 40-cycle period

    localparam int MODE_ACK    = 0;
    localparam int MODE_NACK   = 1;
    localparam int MODE_SILENT = 2;
    localparam int MODE_RESET  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] tx_data;
    logic       ps2c_oe, ps2d_oe, busy, done, ack_err;
    logic       dev_c_low, dev_d_low;
    logic       ps2c_line, ps2d_line;

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;

    // Open-drain bus with pull-ups: a line is low if either side pulls it.
    assign ps2c_line = ~(ps2c_oe | dev_c_low);
    assign ps2d_line = ~(ps2d_oe | dev_d_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .tx_data(tx_data),
        .ps2c_in(ps2c_line),
        .ps2d_in(ps2d_line),
        .ps2c_oe(ps2c_oe),
        .ps2d_oe(ps2d_oe),
        .busy   (busy),
        .done   (done),
        .ack_err(ack_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        if (done === 1'b1) done_cnt++;
    endtask

    // Line levels the device should see in each slot:
    // [0] start, [8:1] data LSB first, [9] odd parity, [10] stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        int   ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic run_frame(input logic [7:0] b, input int mode, input bit dup);
        logic [10:0] exp_bits;
        logic [10:0] got_bits;
        int          hi;
        int          d_rise;
        int          n;
        exp_bits = frame_bits(b);
        got_bits = '0;
        done_cnt = 0;

        tx_data = b;
        start   = 1'b1;
        tick;
        start   = 1'b0;
        tx_data = 8'($urandom);
        check_eq("busy_after_start", busy, 1);

        hi     = 0;
        d_rise = -1;
        while (ps2c_oe === 1'b1 && hi < 50) begin
            if (ps2d_oe === 1'b1 && d_rise < 0) d_rise = hi;
            hi++;
            tick;
        end
        check_eq("inhibit_len", hi, INH + 1);
        check_eq("rts_cycle", d_rise, INH);
        check_eq("start_bit_held", ps2d_oe, 1);

        if (mode == MODE_SILENT) begin
            n = 0;
            while (done !== 1'b1 && n < TMO + 100) begin
                tick;
                n++;
            end
            check_eq("timeout_cycles", n, TMO);
            check_eq("timeout_ack_err", ack_err, 1);
            check_eq("timeout_released", {ps2c_oe, ps2d_oe, busy}, 0);
            tick;
            check_eq("timeout_done_len", done, 0);
            check_eq("timeout_done_count", done_cnt, 1);
            return;
        end

        repeat (10) tick;
        for (int k = 0; k < 11; k++) begin
            repeat (HALF / 2) tick;
            got_bits[k] = ps2d_line;
            if (dup && k == 3) begin
                tx_data = 8'h12;
                start   = 1'b1;
                tick;
                start   = 1'b0;
                repeat (HALF / 2 - 1) tick;
            end else if (k == 10) begin
                repeat (5) tick;
                if (mode != MODE_NACK) dev_d_low = 1'b1;
                repeat (HALF / 2 - 5) tick;
            end else begin
                repeat (HALF / 2) tick;
            end
            dev_c_low = 1'b1;
            if (mode == MODE_RESET && k == 4) begin
                reset = 1'b0;
                #1;
                check_eq("reset_immediate", {ps2c_oe, ps2d_oe, busy, done, ack_err}, 0);
                check_eq("reset_slots", got_bits[4:0], exp_bits[4:0]);
                dev_c_low = 1'b0;
                repeat (3) tick;
                check_eq("reset_held", {ps2c_oe, ps2d_oe, busy, done, ack_err}, 0);
                reset = 1'b1;
                tick;
                return;
            end
            if (k == 4) check_eq("busy_mid", busy, 1);
            repeat (HALF) tick;
            dev_c_low = 1'b0;
            dev_d_low = 1'b0;
        end

        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick;
            n++;
        end
        check_eq("done_seen", done, 1);
        check_eq("ack_err", ack_err, (mode == MODE_NACK) ? 1 : 0);
        check_eq("lines_released", {ps2c_oe, ps2d_oe, busy}, 0);
        for (int k = 0; k < 11; k++)
            check_eq($sformatf("slot%0d_byte%02h", k, b), got_bits[k], exp_bits[k]);
        tick;
        check_eq("done_len", done, 0);
        check_eq("ack_err_hold", ack_err, (mode == MODE_NACK) ? 1 : 0);
        check_eq("done_count", done_cnt, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        tx_data   = 8'h00;
        dev_c_low = 1'b0;
        dev_d_low = 1'b0;
        repeat (3) tick;
        check_eq("reset_state", {ps2c_oe, ps2d_oe, busy, done, ack_err}, 0);
        reset = 1'b1;
        repeat (2) tick;
        check_eq("idle_state", {ps2c_oe, ps2d_oe, busy, done, ack_err}, 0);

        run_frame(8'hED, MODE_ACK, 1'b0);
        run_frame(8'h00, MODE_ACK, 1'b0);
        run_frame(8'hFF, MODE_ACK, 1'b0);
        run_frame(8'h01, MODE_ACK, 1'b0);
        run_frame(8'h55, MODE_NACK, 1'b0);
        run_frame(8'hF4, MODE_SILENT, 1'b0);
        run_frame(8'($urandom), MODE_ACK, 1'b0);
        run_frame(8'h3C, MODE_RESET, 1'b0);
        run_frame(8'hFF, MODE_ACK, 1'b0);
        run_frame(8'hA7, MODE_ACK, 1'b1);
        for (int i = 0; i < 6; i++)
            run_frame(8'($urandom), ($urandom_range(0, 3) == 0) ? MODE_NACK : MODE_ACK, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
